// File: rtl/ft60x_responder.sv
// FT60x-style bus responder: an RX FIFO loaded by the host and read by the master over
// the shared bus, and a TX FIFO written by the master and drained by the host capture port.
module ft60x_responder #(
    parameter int D_BIT  = 32,
    parameter int BE_BIT = 4,
    parameter int DEPTH  = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    inout  wire  [D_BIT-1:0]  ioDATA,
    inout  wire  [BE_BIT-1:0] ioBE,
    input  logic              iOE_N,
    input  logic              iRD_N,
    input  logic              iWR_N,
    output logic              oRXF_N,
    output logic              oTXE_N,
    input  logic [D_BIT-1:0]  iLD_DATA,
    input  logic [BE_BIT-1:0] iLD_BE,
    input  logic              iLD_VALID,
    output logic              oLD_READY,
    output logic [D_BIT-1:0]  oCAP_DATA,
    output logic [BE_BIT-1:0] oCAP_BE,
    output logic              oCAP_VALID,
    input  logic              iCAP_READY,
    output logic              oERR
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = BE_BIT + D_BIT;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] rxMem [DEPTH];
    logic [EW-1:0] txMem [DEPTH];
    logic [AW-1:0] rxWrPtr, rxRdPtr, txWrPtr, txRdPtr;
    logic [CW-1:0] rxCount, txCount, rxCountNext, txCountNext;
    logic          rxfN, txeN, ldReady, errFlag;
    logic          busConflict, driveBus, rxPush, rxPop, txPush, txPop;
    logic [EW-1:0] rxHead, txHead;

    // Flags are registered, so every push/pop qualifier depends only on state and strobes.
    assign busConflict = !iOE_N && !iWR_N;
    assign driveBus    = !iOE_N && iWR_N && !iRST;
    assign rxPush      = iLD_VALID && ldReady;
    assign rxPop       = !iOE_N && !iRD_N && iWR_N && !rxfN;
    assign txPush      = !iWR_N && iOE_N && !txeN;
    assign txPop       = oCAP_VALID && iCAP_READY;

    assign rxHead = rxMem[rxRdPtr];
    assign txHead = txMem[txRdPtr];

    assign ioDATA = driveBus ? rxHead[D_BIT-1:0]  : 'z;
    assign ioBE   = driveBus ? rxHead[EW-1:D_BIT] : 'z;

    assign oRXF_N     = rxfN;
    assign oTXE_N     = txeN;
    assign oLD_READY  = ldReady;
    assign oERR       = errFlag;
    assign oCAP_DATA  = txHead[D_BIT-1:0];
    assign oCAP_BE    = txHead[EW-1:D_BIT];
    assign oCAP_VALID = (txCount != '0);

    always_comb begin
        rxCountNext = rxCount;
        txCountNext = txCount;
        if (rxPush && !rxPop) rxCountNext = rxCount + 1'b1;
        else if (!rxPush && rxPop) rxCountNext = rxCount - 1'b1;
        if (txPush && !txPop) txCountNext = txCount + 1'b1;
        else if (!txPush && txPop) txCountNext = txCount - 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            txWrPtr <= '0;
            txRdPtr <= '0;
            rxCount <= '0;
            txCount <= '0;
            rxfN    <= 1'b1;
            txeN    <= 1'b1;
            ldReady <= 1'b0;
            errFlag <= 1'b0;
        end else begin
            if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
            if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
            if (txPush) txWrPtr <= txWrPtr + 1'b1;
            if (txPop)  txRdPtr <= txRdPtr + 1'b1;
            rxCount <= rxCountNext;
            txCount <= txCountNext;
            rxfN    <= (rxCountNext == '0);
            txeN    <= (txCountNext == FULL);
            ldReady <= (rxCountNext != FULL);
            errFlag <= errFlag || busConflict;
        end
    end

    // Storage is left uncleared by reset; only the pointers define what is valid.
    always_ff @(posedge iCLK) begin
        if (!iRST && rxPush) rxMem[rxWrPtr] <= {iLD_BE, iLD_DATA};
        if (!iRST && txPush) txMem[txWrPtr] <= {ioBE, ioDATA};
    end
endmodule

// File: tb/tb_ft60x_responder.sv
// Directed scoreboard bench for ft60x_responder: words are queued when loaded or written
// and compared when they appear on the FT60x bus or the capture port.
module tb_ft60x_responder;
    logic        iCLK = 1'b0;
    logic        iRST;
    wire  [31:0] ioDATA;
    wire  [3:0]  ioBE;
    logic        iOE_N, iRD_N, iWR_N;
    logic        oRXF_N, oTXE_N;
    logic [31:0] iLD_DATA;
    logic [3:0]  iLD_BE;
    logic        iLD_VALID;
    logic        oLD_READY;
    logic [31:0] oCAP_DATA;
    logic [3:0]  oCAP_BE;
    logic        oCAP_VALID;
    logic        iCAP_READY;
    logic        oERR;

    logic        mDrive;
    logic [31:0] mData;
    logic [3:0]  mBe;

    logic [35:0] rxExp[$];
    logic [35:0] txExp[$];
    int          nTests = 0;
    int          nFail  = 0;

    assign ioDATA = mDrive ? mData : 'z;
    assign ioBE   = mDrive ? mBe   : 'z;

    always #5 iCLK = ~iCLK;

    ft60x_responder #(.D_BIT(32), .BE_BIT(4), .DEPTH(16)) dut (
        .iCLK(iCLK), .iRST(iRST), .ioDATA(ioDATA), .ioBE(ioBE),
        .iOE_N(iOE_N), .iRD_N(iRD_N), .iWR_N(iWR_N),
        .oRXF_N(oRXF_N), .oTXE_N(oTXE_N),
        .iLD_DATA(iLD_DATA), .iLD_BE(iLD_BE), .iLD_VALID(iLD_VALID), .oLD_READY(oLD_READY),
        .oCAP_DATA(oCAP_DATA), .oCAP_BE(oCAP_BE), .oCAP_VALID(oCAP_VALID),
        .iCAP_READY(iCAP_READY), .oERR(oERR)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkRx(input string tag);
        logic [35:0] exp;
        exp = (rxExp.size() != 0) ? rxExp.pop_front() : '1;
        check(tag, {28'd0, ioBE, ioDATA}, {28'd0, exp});
    endtask

    task automatic checkTx(input string tag);
        logic [35:0] exp;
        exp = (txExp.size() != 0) ? txExp.pop_front() : '1;
        check(tag, {28'd0, oCAP_BE, oCAP_DATA}, {28'd0, exp});
    endtask

    task automatic load(input logic [31:0] d, input logic [3:0] be);
        iLD_VALID = 1'b1;
        iLD_DATA  = d;
        iLD_BE    = be;
        rxExp.push_back({be, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRST = 1'b1; iOE_N = 1'b1; iRD_N = 1'b1; iWR_N = 1'b1;
        iLD_VALID = 1'b0; iLD_DATA = '0; iLD_BE = '0; iCAP_READY = 1'b0;
        mDrive = 1'b0; mData = '0; mBe = '0;

        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("reset_rxf",      oRXF_N,     1'b1);
        check("reset_txe",      oTXE_N,     1'b1);
        check("reset_ld_ready", oLD_READY,  1'b0);
        check("reset_cap_vld",  oCAP_VALID, 1'b0);
        check("reset_err",      oERR,       1'b0);
        iRST = 1'b0;
        @(negedge iCLK);
        check("release_txe",      oTXE_N,    1'b0);
        check("release_ld_ready", oLD_READY, 1'b1);
        check("release_rxf",      oRXF_N,    1'b1);

        // Load four words and read them back in one OE/RD burst.
        for (int i = 0; i < 4; i++) begin
            load(32'(32'h11111111 * (i + 1)), 4'hF);
            @(negedge iCLK);
            if (i == 0) check("rxf_first_load", oRXF_N, 1'b0);
        end
        iLD_VALID = 1'b0;
        iOE_N = 1'b0; iRD_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 checkRx("burst_read");
            @(negedge iCLK);
        end
        check("rxf_after_burst", oRXF_N, 1'b1);
        iOE_N = 1'b1; iRD_N = 1'b1;

        // Seventeen writes into a sixteen-entry TX FIFO; the last one must be dropped.
        iWR_N = 1'b0; mDrive = 1'b1;
        for (int i = 0; i < 17; i++) begin
            mData = 32'(i);
            mBe   = 4'(i + 3);
            if (i < 16) txExp.push_back({mBe, mData});
            @(negedge iCLK);
            if (i == 14) check("txe_before_full", oTXE_N, 1'b0);
            if (i == 15) check("txe_full",        oTXE_N, 1'b1);
        end
        iWR_N = 1'b1; mDrive = 1'b0;
        check("txe_stays_full", oTXE_N, 1'b1);
        iCAP_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("cap_valid", oCAP_VALID, 1'b1);
            checkTx("capture");
            @(negedge iCLK);
        end
        iCAP_READY = 1'b0;
        check("cap_drained", oCAP_VALID, 1'b0);
        check("txe_drained", oTXE_N,     1'b0);

        // Count of one with a simultaneous load and bus read.
        load(32'hA5A50001, 4'h3);
        @(negedge iCLK);
        load(32'h5A5A0002, 4'hC);
        iOE_N = 1'b0; iRD_N = 1'b0;
        #1 checkRx("simul_read");
        @(negedge iCLK);
        iLD_VALID = 1'b0;
        check("simul_rxf", oRXF_N, 1'b0);
        #1 checkRx("simul_next_word");
        @(negedge iCLK);
        check("simul_drained", oRXF_N, 1'b1);
        iOE_N = 1'b1; iRD_N = 1'b1;

        // Reset in the middle of a read burst with TX data also queued.
        iWR_N = 1'b0; mDrive = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mData = 32'hBEEF0000 + 32'(i);
            mBe   = 4'h6;
            txExp.push_back({mBe, mData});
            @(negedge iCLK);
        end
        iWR_N = 1'b1; mDrive = 1'b0;
        check("tx_queued", oCAP_VALID, 1'b1);
        for (int i = 0; i < 4; i++) begin
            load(32'hE0000001 + 32'(i), 4'hF);
            @(negedge iCLK);
        end
        iLD_VALID = 1'b0;
        iOE_N = 1'b0; iRD_N = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 checkRx("pre_reset_read");
            @(negedge iCLK);
        end
        iRST = 1'b1;
        load(32'hDEADDEAD, 4'hF);
        @(negedge iCLK);
        rxExp.delete();
        txExp.delete();
        check("midreset_rxf",      oRXF_N,     1'b1);
        check("midreset_txe",      oTXE_N,     1'b1);
        check("midreset_ld_ready", oLD_READY,  1'b0);
        check("midreset_cap_vld",  oCAP_VALID, 1'b0);
        iRST = 1'b0; iLD_VALID = 1'b0; iOE_N = 1'b1; iRD_N = 1'b1;
        @(negedge iCLK);
        check("post_reset_txe",      oTXE_N,     1'b0);
        check("post_reset_ld_ready", oLD_READY,  1'b1);
        check("post_reset_rxf",      oRXF_N,     1'b1);
        check("post_reset_cap_vld",  oCAP_VALID, 1'b0);

        // Read strobe while empty: the stale word in slot 0 stays on the bus, nothing pops.
        iOE_N = 1'b0; iRD_N = 1'b0;
        #1 check("stale_head", {28'd0, ioBE, ioDATA}, {28'd0, 4'hF, 32'h11111111});
        @(negedge iCLK);
        check("empty_rd_rxf", oRXF_N, 1'b1);
        check("empty_rd_err", oERR,   1'b0);
        #1 check("stale_head_again", {28'd0, ioBE, ioDATA}, {28'd0, 4'hF, 32'h11111111});
        @(negedge iCLK);
        iRD_N = 1'b1;
        load(32'hC0DEC0DE, 4'h9);
        @(negedge iCLK);
        iLD_VALID = 1'b0;
        check("load_after_empty_rxf", oRXF_N, 1'b0);
        #1 check("load_after_empty_head", {28'd0, ioBE, ioDATA}, {28'd0, rxExp[0]});

        // OE and WR both low: responder must release the bus and flag the error.
        iWR_N = 1'b0; iRD_N = 1'b0; mDrive = 1'b1; mData = '0; mBe = '0;
        #1 check("conflict_bus", {28'd0, ioBE, ioDATA}, 64'd0);
        @(negedge iCLK);
        iWR_N = 1'b1; iRD_N = 1'b1; mDrive = 1'b0;
        check("conflict_err",     oERR,       1'b1);
        check("conflict_rxf",     oRXF_N,     1'b0);
        check("conflict_cap_vld", oCAP_VALID, 1'b0);
        @(negedge iCLK);
        check("err_sticky", oERR, 1'b1);
        iRD_N = 1'b0;
        #1 checkRx("conflict_no_pop");
        @(negedge iCLK);
        check("conflict_read_rxf", oRXF_N, 1'b1);
        check("err_still_set",     oERR,   1'b1);
        iOE_N = 1'b1; iRD_N = 1'b1;
        iRST = 1'b1;
        @(negedge iCLK);
        check("err_cleared", oERR, 1'b0);
        iRST = 1'b0;
        @(negedge iCLK);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
